spi_encoder_master: RTL

SPI master that drives the decoder's slave SPI port. It Hamming SECDED-encodes 26-bit host payloads into 32-bit codewords and optionally XORs in an error-injection mask. It then issues 48-bit SPI frames (control byte, address byte, 32-bit codeword) and, when read-back is compiled in, captures MISO data from read frames. It sits directly upstream of the decoder and serves as the stimulus and host-side bridge for the error-correction path.

---
 rtl/spi_enc_pkg.sv | 22 ++
 rtl/spi_encoder_master_if.sv | 10 +
 rtl/spi_encoder_master_hamming.sv | 35 +++
 rtl/spi_encoder_master.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/spi_enc_pkg.sv
// Shared types and constants for the SECDED-encoding SPI master.
// FSM state encoding, frame geometry, SPI opcodes and Hamming parity positions.
package spi_enc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENCODE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } state_t;

  localparam int FRAME_BITS = 48;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;

  // Hamming parity bits live at codeword positions 1, 2, 4, 8 and 16.
  localparam int N_PARITY = 5;
  localparam logic [31:0] PARITY_MASK = 32'h0001_0116;

endpackage

// File: rtl/spi_encoder_master_if.sv
// SPI pin bundle between the encoding master and the decoder's slave port.
interface spi_encoder_master_if;
  logic spi_clk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_clk, output spi_cs_n, output spi_mosi, input spi_miso);
  modport slave (input spi_clk, input spi_cs_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_encoder_master_hamming.sv
// Combinational Hamming(31,26) encoder with an overall even-parity bit at position 0.
module hamming_secded_enc
  import spi_enc_pkg::*;
(
  input  logic [25:0] data,
  output logic [31:0] codeword
);

  logic [31:0] cw;
  logic        par;
  int          k;

  always_comb begin
    cw  = '0;
    par = 1'b0;
    k   = 0;
    for (int pos = 1; pos < 32; pos++) begin
      if (!PARITY_MASK[pos]) begin
        cw[pos] = data[k];
        k = k + 1;
      end
    end
    // Parity bit 2^p covers every data position whose index has bit p set.
    for (int p = 0; p < N_PARITY; p++) begin
      par = 1'b0;
      for (int pos = 1; pos < 32; pos++) begin
        if (pos[p] && !PARITY_MASK[pos]) par = par ^ cw[pos];
      end
      cw[1 << p] = par;
    end
    cw[0] = ^cw[31:1];
    codeword = cw;
  end

endmodule

// File: rtl/spi_encoder_master.sv
// SPI master: SECDED-encodes a 26-bit payload and sends a 48-bit {ctrl, addr, payload} frame.
// Optional MISO read-back is compiled in with `define SPI_MASTER_READBACK_EN.
module spi_encoder_master
  import spi_enc_pkg::*;
#(
  parameter int CLK_DIV        = 2,
  parameter int SPI_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      op,
  input  logic [SPI_ADDR_WIDTH-1:0] addr,
  input  logic [25:0]               data_in,
  input  logic [DATA_WIDTH-1:0]     inj_mask,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     tx_codeword,
  output logic [DATA_WIDTH-1:0]     rd_data,
  spi_encoder_master_if.master      spi
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t                    state_q, state_d;
  logic [7:0]                div_q, div_d;
  logic [5:0]                bit_q, bit_d;
  logic                      phase_q, phase_d;
  logic                      cs_n_q, cs_n_d;
  logic                      sclk_q, sclk_d;
  logic                      mosi_q, mosi_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [DATA_WIDTH-1:0]     tx_q, tx_d;
  logic [FRAME_BITS-1:0]     frame_q, frame_d;
  logic [SPI_ADDR_WIDTH-1:0] addr_q;
  logic [25:0]               data_q;
  logic [DATA_WIDTH-1:0]     mask_q;
  logic [DATA_WIDTH-1:0]     cw, cw_masked;
  logic                      accept, sample, capture, is_read;

  hamming_secded_enc u_enc (
    .data     (data_q),
    .codeword (cw)
  );

  assign accept    = (state_q == IDLE) && start;
  assign cw_masked = cw ^ mask_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_d    = tx_q;
    frame_d = frame_q;
    sample  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ENCODE;
          busy_d  = 1'b1;
        end
      end
      ENCODE: begin
        tx_d    = cw_masked;
        frame_d = is_read ? {OP_READ, addr_q, {DATA_WIDTH{1'b0}}}
                          : {OP_WRITE, addr_q, cw_masked};
        cs_n_d  = 1'b0;
        mosi_d  = frame_d[FRAME_BITS-1];
        div_d   = DIV_LAST;
        state_d = CS_SETUP;
      end
      CS_SETUP: begin
        if (div_q == 8'd0) begin
          state_d = SHIFT;
          div_d   = DIV_LAST;
          bit_d   = 6'(FRAME_BITS - 1);
          phase_d = 1'b0;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      SHIFT: begin
        if (div_q != 8'd0) begin
          div_d = div_q - 8'd1;
        end else begin
          div_d = DIV_LAST;
          if (!phase_q) begin
            sclk_d  = 1'b1;
            phase_d = 1'b1;
            sample  = 1'b1;
          end else begin
            // Falling edge: advance to the next bit, or finish after bit 0.
            sclk_d  = 1'b0;
            phase_d = 1'b0;
            if (bit_q == 6'd0) begin
              state_d = CS_HOLD;
            end else begin
              bit_d   = bit_q - 6'd1;
              frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
              mosi_d  = frame_q[FRAME_BITS-2];
            end
          end
        end
      end
      CS_HOLD: begin
        if (div_q == 8'd0) begin
          state_d = DONE;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          capture = is_read;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= addr;
      data_q <= data_in;
      mask_q <= inj_mask;
    end
    frame_q <= frame_d;
  end

`ifdef SPI_MASTER_READBACK_EN
  logic                  op_q;
  logic [DATA_WIDTH-1:0] rx_q, rd_q;

  always_ff @(posedge clk) begin
    if (accept) op_q <= op;
    if (sample) rx_q <= {rx_q[DATA_WIDTH-2:0], spi.spi_miso};
  end

  always_ff @(posedge clk) begin
    if (reset)        rd_q <= '0;
    else if (capture) rd_q <= rx_q;
  end

  assign is_read = op_q;
  assign rd_data = rd_q;
`else
  logic unused_readback;
  assign unused_readback = ^{op, sample, capture, spi.spi_miso};
  assign is_read = 1'b0;
  assign rd_data = '0;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign tx_codeword  = tx_q;
  assign spi.spi_clk  = sclk_q;
  assign spi.spi_cs_n = cs_n_q;
  assign spi.spi_mosi = mosi_q;

endmodule
